// File: rtl/apb_wb_bridge_pkg.sv
// Shared types and width helpers for the APB-to-Wishbone bridge.
package apb_wb_pkg;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } apb_wb_state_t;

    // Number of byte lanes for a given data width.
    function automatic int SEL_W(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_wb_bridge_timeout.sv
// Bus-timeout counter: cleared when a Wishbone cycle starts, counts while the
// bridge waits on the slave, and flags expiry on reaching TIMEOUT.
// TIMEOUT = 0 removes the counter entirely and never expires.
module apb_wb_timeout
    import apb_wb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] count;

            // Count cycles spent waiting on the slave; hold once the limit is hit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (run && (count != LIMIT)) begin
                    count <= count + CNT_W'(1);
                end
            end

            assign expired = (count == LIMIT);
        end else begin : g_off
            logic unused_ctl;
            assign unused_ctl = ^{clk, reset, clear, run};
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_wb_bridge.sv
// APB slave front end driving a pipelined Wishbone master, one transfer at a
// time. Wishbone error and bus timeout both surface as PSLVERR.
module apb_wb_bridge
    import apb_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [ADDR_WIDTH-1:0]                        apb_PADDR,
    input  logic                                         apb_PSEL,
    input  logic                                         apb_PENABLE,
    input  logic                                         apb_PWRITE,
    input  logic [DATA_WIDTH-1:0]                        apb_PWDATA,
    input  logic [SEL_W(DATA_WIDTH)-1:0]                 apb_PSTRB,
    output logic                                         apb_PREADY,
    output logic [DATA_WIDTH-1:0]                        apb_PRDATA,
    output logic                                         apb_PSLVERR,
    output logic                                         wb_cyc,
    output logic                                         wb_stb,
    output logic                                         wb_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0]                        wb_data_o,
    output logic [SEL_W(DATA_WIDTH)-1:0]                 wb_sel,
    input  logic                                         wb_stall,
    input  logic                                         wb_ack,
    input  logic                                         wb_err,
    input  logic [DATA_WIDTH-1:0]                        wb_data_i
);

    localparam int BYTE_OFF = $clog2(SEL_W(DATA_WIDTH));

    apb_wb_state_t state;

    logic start;
    logic in_bus;
    logic resp_ok;
    logic done;
    logic abort;
    logic expired;

    // A strobe is only accepted when not stalled; once accepted, any ack/err
    // in WAIT completes the cycle. Completion beats a simultaneous timeout.
    assign start   = (state == IDLE) && apb_PSEL && apb_PENABLE;
    assign in_bus  = (state == REQ) || (state == WAIT);
    assign resp_ok = (state == WAIT) || ((state == REQ) && !wb_stall);
    assign done    = resp_ok && (wb_ack || wb_err);
    assign abort   = in_bus && !done && expired;

    generate
        if (BYTE_OFF > 0) begin : g_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^apb_PADDR[BYTE_OFF-1:0];
        end
    endgenerate

    apb_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .run     (in_bus),
        .expired (expired)
    );

    // Bridge sequencer: latch the APB request, run the Wishbone cycle, then
    // present a single-cycle PREADY with registered data and error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data_o   <= '0;
            wb_sel      <= '0;
            apb_PREADY  <= 1'b0;
            apb_PSLVERR <= 1'b0;
            apb_PRDATA  <= '0;
        end else begin
            apb_PREADY <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        wb_cyc    <= 1'b1;
                        wb_stb    <= 1'b1;
                        wb_we     <= apb_PWRITE;
                        wb_addr   <= apb_PADDR[ADDR_WIDTH-1:BYTE_OFF];
                        wb_data_o <= apb_PWDATA;
                        wb_sel    <= apb_PWRITE ? apb_PSTRB : '1;
                    end
                end
                REQ, WAIT: begin
                    if (done) begin
                        state       <= RESP;
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        apb_PREADY  <= 1'b1;
                        apb_PSLVERR <= wb_err;
                        apb_PRDATA  <= (!wb_we && !wb_err) ? wb_data_i : '0;
                    end else if (abort) begin
                        state       <= RESP;
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        apb_PREADY  <= 1'b1;
                        apb_PSLVERR <= 1'b1;
                        apb_PRDATA  <= '0;
                    end else if (resp_ok) begin
                        // Strobe accepted with no response yet.
                        state  <= WAIT;
                        wb_stb <= 1'b0;
                    end
                end
                RESP: begin
                    // The APB access phase is still visible here; it is not a new request.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wb_bridge.sv
// Directed bench for apb_wb_bridge with an expected-response scoreboard.
module tb_apb_wb_bridge;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk;
    logic          reset;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [2:0]    wadr;
    logic [DW-1:0] wdo;
    logic [3:0]    sel;
    logic          stall;
    logic          ack;
    logic          err;
    logic [DW-1:0] wdi;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;

    apb_wb_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .apb_PADDR   (paddr),
        .apb_PSEL    (psel),
        .apb_PENABLE (penable),
        .apb_PWRITE  (pwrite),
        .apb_PWDATA  (pwdata),
        .apb_PSTRB   (pstrb),
        .apb_PREADY  (pready),
        .apb_PRDATA  (prdata),
        .apb_PSLVERR (pslverr),
        .wb_cyc      (cyc),
        .wb_stb      (stb),
        .wb_we       (we),
        .wb_addr     (wadr),
        .wb_data_o   (wdo),
        .wb_sel      (sel),
        .wb_stall    (stall),
        .wb_ack      (ack),
        .wb_err      (err),
        .wb_data_i   (wdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One APB access against a scripted slave. Offsets k count cycles after
    // the access cycle n: the strobe is stalled for k=1..stall_n, accepted at
    // stall_n+1, and answered ack_dly cycles after acceptance.
    task automatic run_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] strb,
                           input int stall_n, input int ack_dly, input bit use_err,
                           input bit no_resp, input int late_ack, input logic [DW-1:0] rdata,
                           input int exp_ready, input int exp_stb);
        exp_t e;
        exp_t got;
        int   stb_cnt;
        int   rdy_cnt;
        int   rdy_at;
        int   accept;
        bit   seen_stb;
        stb_cnt  = 0;
        rdy_cnt  = 0;
        rdy_at   = -10;
        seen_stb = 0;
        accept   = stall_n + 1;
        e.data   = (wr || use_err || no_resp) ? '0 : rdata;
        e.err    = use_err || no_resp;
        sb_q.push_back(e);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        for (int k = 1; k <= exp_ready + 4; k++) begin
            @(negedge clk);
            if (stb) begin
                stb_cnt++;
                if (!seen_stb) begin
                    seen_stb = 1;
                    chk({name, "/stb_at"}, k, 1);
                    chk({name, "/wb_addr"}, wadr, addr[AW-1:2]);
                    chk({name, "/wb_sel"}, sel, wr ? strb : 4'hF);
                    chk({name, "/wb_we"}, we, wr);
                    if (wr) chk({name, "/wb_data_o"}, wdo, wdata);
                end
            end
            if (pready) begin
                rdy_cnt++;
                if (rdy_cnt == 1) rdy_at = k;
                chk({name, "/cyc_at_ready"}, cyc, 0);
                chk({name, "/sb_avail"}, sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    chk({name, "/pslverr"}, pslverr, got.err);
                    chk({name, "/prdata"}, prdata, got.data);
                end
            end
            if (k == late_ack) chk({name, "/cyc_late"}, cyc, 0);
            if (k == rdy_at + 1) begin
                psel = 1'b0; penable = 1'b0;
            end
            stall = (k <= stall_n);
            ack   = (!no_resp && !use_err && (k == accept + ack_dly)) || (k == late_ack);
            err   = !no_resp && use_err && (k == accept + ack_dly);
            wdi   = (ack || err) ? rdata : 32'hA5A5_5A5A;
        end
        psel = 1'b0; penable = 1'b0; stall = 1'b0; ack = 1'b0; err = 1'b0;
        chk({name, "/ready_at"}, rdy_at, exp_ready);
        chk({name, "/ready_pulses"}, rdy_cnt, 1);
        chk({name, "/stb_cycles"}, stb_cnt, exp_stb);
    endtask

    initial begin
        int rdy_seen;
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; stall = 1'b0; ack = 1'b0; err = 1'b0; wdi = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {cyc, stb, we, pready, pslverr, wadr, sel}, '0);
        chk("reset_data", {prdata, wdo}, '0);
        reset = 1'b0;

        // Write, same-cycle ack.
        run_txn("wr_fast", 1'b1, 5'h0C, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2, 1);
        // Read, three stall cycles, ack one cycle after acceptance.
        run_txn("rd_stall", 1'b0, 5'h10, 32'h0, 4'h0, 3, 1, 0, 0, 0, 32'h12345678, 2 + 3 + 1, 4);
        // Partial-strobe write, ack two cycles after acceptance.
        run_txn("wr_strb5", 1'b1, 5'h04, 32'hCAFEF00D, 4'h5, 0, 2, 0, 0, 0, 32'h0, 2 + 2, 1);
        // Slave never responds; late ack at n+12 must be ignored.
        run_txn("timeout", 1'b0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 1, 12, 32'h77777777, TMO + 2, 1);
        // Error completion, then a clean read.
        run_txn("rd_err", 1'b0, 5'h14, 32'h0, 4'h0, 0, 1, 1, 0, 0, 32'h99999999, 2 + 1, 1);
        run_txn("rd_clean", 1'b0, 5'h18, 32'h0, 4'h0, 1, 0, 0, 0, 0, 32'h0BADF00D, 2 + 1, 2);

        // Reset while the bridge waits for a response.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 5'h00; pwrite = 1'b1; pwdata = 32'h1; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wait/cyc_before", {cyc, stb}, 2'b10);
        reset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait/cyc_after", {cyc, stb}, 2'b00);
        rdy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (pready) rdy_seen++;
            @(negedge clk);
        end
        chk("rst_wait/no_ready", rdy_seen, 0);

        run_txn("wr_post_rst", 1'b1, 5'h1C, 32'h55AA55AA, 4'h3, 0, 0, 0, 0, 0, 32'h0, 2, 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
